rom_load_controller: RTL and testbench
======================================

# rom_load_controller

Sequences reads from the `rom_memory` weight ROM and streams the words to a downstream consumer, such as the PE-array weight loader, over a valid/ready handshake. A single `start_i` pulse walks addresses 0..FINISH_MEM in order. Each ROM word is registered into a one-entry output stage, and the block sustains one word per cycle while the consumer holds `ready_i` high. The block sits between the ROM (which has a combinational read gated by `rd_mem_ld_i`) and the array-load logic.

## Interface
- MEMORY_WIDTH, 72, ROM word width in bits.
- ADDRS_WIDTH, 8, ROM address width in bits.
- FINISH_MEM, 4, last address read; a run covers FINISH_MEM+1 words. Must be below 2^ADDRS_WIDTH.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_i  in  1  starts a run; sampled only in IDLE.
- abort_i  in  1  synchronous abort; returns to IDLE.
- addrs_mem_o  out  ADDRS_WIDTH  ROM address; drives `addrs_mem_i`.
- rd_mem_ld_o  out  1  ROM read enable; drives `rd_mem_ld_i`.
- mem_data_i  in  MEMORY_WIDTH  ROM read data, combinational from the address.
- data_o  out  MEMORY_WIDTH  registered word to the consumer.
- valid_o  out  1  `data_o` holds an unconsumed word.
- ready_i  in  1  consumer accepts `data_o`.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE → READ:
  - on `start_i`=1;
  - address counter is loaded with 0.
- READ:
  - `rd_mem_ld_o`=1 only when the output stage can take a word: `!valid_o || ready_i`. Otherwise it is 0.
  - When a read fires, `data_o`←`mem_data_i` and `valid_o`←1 at the next edge.
  - If the read address equals FINISH_MEM, the FSM goes to DRAIN. Otherwise the address increments.
- DRAIN:
  - `rd_mem_ld_o`=0.
  - When `valid_o && ready_i`, `valid_o`←0, `done_o` pulses, and the FSM goes to IDLE.
- Handshake rules:
  - A word transfers on an edge with `valid_o && ready_i`.
  - `data_o` stays stable while `valid_o && !ready_i`.
  - A read and a transfer in the same cycle leave `valid_o` at 1 and load the new word.
- Address counter:
  - ADDRS_WIDTH bits.
  - Never exceeds FINISH_MEM.
  - Never wraps, except under LOOP (see Configuration).
- `abort_i` has priority over every other input in every state. At the next edge: state←IDLE, `valid_o`←0, address←0, no `done_o`.
- `start_i` is ignored while `busy_o`=1.
- FINISH_MEM=0: a run is a single word, and the FSM goes READ→DRAIN on the first read.
- `addrs_mem_o` is a registered counter and equals 0 in IDLE.

## Timing
- Reset values: state IDLE, `addrs_mem_o`=0, `rd_mem_ld_o`=0, `data_o`=0, `valid_o`=0, `busy_o`=0, `done_o`=0.
- Reset asserted mid-run returns all outputs to these values immediately (asynchronously).
- `start_i` at edge N puts the FSM in READ at N+1. The first read fires in cycle N+1, and `valid_o`=1 from edge N+2.
- With `ready_i` held at 1, words 0..FINISH_MEM appear on consecutive cycles. The last word is accepted at edge N+FINISH_MEM+3.
- `done_o` is high for the cycle following the last accepted transfer. The FSM is in IDLE in that same cycle.
- A new `start_i` is accepted when `done_o` is high.
- `busy_o` is registered from the state: it is high from N+1 until the last transfer edge.

## Configuration
- Macro `ROM_CTRL_LOOP_EN`.
- Defined:
  - adds input port `loop_i` (1 bit);
  - if `loop_i`=1 when the read of FINISH_MEM fires, the address wraps to 0 and the FSM stays in READ, streaming without a gap;
  - a run then ends only through `abort_i`, or when `loop_i`=0 at a FINISH_MEM read;
  - `done_o` pulses only at that final drain.
- Undefined:
  - `loop_i` does not exist;
  - behaviour is exactly single-pass as described above.

## Test plan
- Reset, then a `start_i` pulse with FINISH_MEM=4 and `ready_i`=1 → addresses 0,1,2,3,4 on consecutive cycles; `data_o` shows the contents of addresses 0..4 from edge N+2; `done_o` pulses once; `busy_o` falls after 6 cycles.
- `ready_i` toggling 1,0,0,1… → `data_o` is held while stalled; `rd_mem_ld_o`=0 during stalls; no word is lost or duplicated; 5 transfers in total.
- `abort_i` during the read of address 2 → next cycle: IDLE, `valid_o`=0, `addrs_mem_o`=0, no `done_o`. A following `start_i` restarts at address 0.
- `start_i` held high through a whole run → exactly one run; the next run begins at the edge after `done_o`.
- `reset_n` low mid-run with `valid_o`=1 → all outputs go to their reset values immediately, without a clock edge.
- With `ROM_CTRL_LOOP_EN` and `loop_i`=1 for 12 words, then 0 → addresses 0..4,0..4,0..4 on consecutive cycles, then drain; one `done_o` after 15 transfers.

Source files
------------

// File: rtl/rom_load_controller.sv
// Walks ROM addresses 0..FINISH_MEM and streams each word through a one-entry valid/ready output stage.
// Optional `ROM_CTRL_LOOP_EN adds loop_i: wrap to address 0 at FINISH_MEM instead of draining.
module rom_load_controller #(
    parameter int MEMORY_WIDTH = 72,
    parameter int ADDRS_WIDTH  = 8,
    parameter int FINISH_MEM   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start_i,
    input  logic                    abort_i,
`ifdef ROM_CTRL_LOOP_EN
    input  logic                    loop_i,
`endif
    output logic [ADDRS_WIDTH-1:0]  addrs_mem_o,
    output logic                    rd_mem_ld_o,
    input  logic [MEMORY_WIDTH-1:0] mem_data_i,
    output logic [MEMORY_WIDTH-1:0] data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDRS_WIDTH-1:0] LP_FINISH = ADDRS_WIDTH'(FINISH_MEM);
    localparam logic [ADDRS_WIDTH-1:0] LP_ONE    = ADDRS_WIDTH'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDRS_WIDTH-1:0]  r_addr;
    logic [ADDRS_WIDTH-1:0]  w_addr_nxt;
    logic [MEMORY_WIDTH-1:0] r_data;
    logic [MEMORY_WIDTH-1:0] w_data_nxt;
    logic                    r_valid;
    logic                    w_valid_nxt;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    w_rd;
    logic                    w_loop;

`ifdef ROM_CTRL_LOOP_EN
    assign w_loop = loop_i;
`else
    assign w_loop = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, read strobe and output-stage update; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_done_nxt  = 1'b0;
        w_rd        = 1'b0;
        if (abort_i) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_addr_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        w_state_nxt = ST_READ;
                        w_addr_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_READ: begin
                    w_rd = !r_valid || ready_i;
                    if (w_rd) begin
                        w_data_nxt  = mem_data_i;
                        w_valid_nxt = 1'b1;
                        if (r_addr == LP_FINISH) begin
                            if (w_loop) begin
                                w_addr_nxt = '0;
                            end else begin
                                w_state_nxt = ST_DRAIN;
                            end
                        end else begin
                            w_addr_nxt = r_addr + LP_ONE;
                        end
                    end else begin
                        w_valid_nxt = r_valid;
                    end
                end
                ST_DRAIN: begin
                    if (r_valid && ready_i) begin
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_addr_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                    w_addr_nxt  = '0;
                end
            endcase
        end
    end

    // Address counter, output stage and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign addrs_mem_o = r_addr;
    assign rd_mem_ld_o = w_rd;
    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

endmodule

// File: tb/tb_rom_load_controller.sv
// Self-checking bench for rom_load_controller against a transfer-count reference model and a random ROM image.
module tb_rom_load_controller;

    localparam int MW = 72;
    localparam int AW = 8;
    localparam int F  = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start_i;
    logic          abort_i;
    logic          loop_i;
    logic [AW-1:0] addrs_mem_o;
    logic          rd_mem_ld_o;
    logic [MW-1:0] mem_data_i;
    logic [MW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic          busy_o;
    logic          done_o;

    logic [MW-1:0] rom [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_data_i = rd_mem_ld_o ? rom[addrs_mem_o] : {MW{1'b1}};

    rom_load_controller #(.MEMORY_WIDTH(MW), .ADDRS_WIDTH(AW), .FINISH_MEM(F)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start_i(start_i),
        .abort_i(abort_i),
`ifdef ROM_CTRL_LOOP_EN
        .loop_i(loop_i),
`endif
        .addrs_mem_o(addrs_mem_o),
        .rd_mem_ld_o(rd_mem_ld_o),
        .mem_data_i(mem_data_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    task automatic test_reset();
        reset_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; loop_i = 1'b0; ready_i = 1'b0;
        #3;
        checks++;
        if ({addrs_mem_o, rd_mem_ld_o, data_o, valid_o, busy_o, done_o} !== '0) begin
            errors++;
            $display("FAIL reset_values addr=%0d rd=%b data=%h valid=%b busy=%b done=%b expected all zero",
                     addrs_mem_o, rd_mem_ld_o, data_o, valid_o, busy_o, done_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ready held high: fixed cycle table derived from the start edge
    task automatic test_stream();
        logic e_busy, e_rd, e_valid, e_done;
        logic [AW-1:0] e_addr;
        @(negedge clk);
        start_i = 1'b1; ready_i = 1'b1;
        for (int k = 1; k <= F + 4; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            e_busy  = (k <= F + 2);
            e_rd    = (k <= F + 1);
            e_valid = (k >= 2) && (k <= F + 2);
            e_done  = (k == F + 3);
            e_addr  = (k <= F + 1) ? AW'(k - 1) : ((k == F + 2) ? AW'(F) : '0);
            checks++;
            if ({busy_o, rd_mem_ld_o, valid_o, done_o} !== {e_busy, e_rd, e_valid, e_done}) begin
                errors++;
                $display("FAIL stream_flags cyc=%0d busy/rd/valid/done=%b%b%b%b expected %b%b%b%b",
                         k, busy_o, rd_mem_ld_o, valid_o, done_o, e_busy, e_rd, e_valid, e_done);
            end
            checks++;
            if (addrs_mem_o !== e_addr) begin
                errors++;
                $display("FAIL stream_addr cyc=%0d got %0d expected %0d", k, addrs_mem_o, e_addr);
            end
            if (e_valid) begin
                checks++;
                if (data_o !== rom[k - 2]) begin
                    errors++;
                    $display("FAIL stream_data cyc=%0d got %h expected %h", k, data_o, rom[k - 2]);
                end
            end
        end
    endtask

    // random ready with an initial 1,0,0,1 pattern; model tracks reads and transfers
    task automatic test_stall();
        int reads = 0;
        int xfers = 0;
        int cyc = 0;
        logic e_valid, e_rd, prev_stall;
        logic [MW-1:0] prev_data;
        logic [3:0] pat;
        pat = 4'b1001;
        prev_stall = 1'b0;
        prev_data = '0;
        @(negedge clk);
        start_i = 1'b1; ready_i = 1'b0;
        while (xfers < F + 1 && cyc < 200) begin
            @(negedge clk);
            start_i = 1'b0;
            ready_i = (cyc < 4) ? pat[3 - cyc] : 1'($urandom_range(0, 1));
            cyc++;
            #1;
            e_valid = ((reads - xfers) == 1);
            e_rd = (reads <= F) && (!e_valid || ready_i);
            checks++;
            if ({valid_o, rd_mem_ld_o, busy_o, done_o} !== {e_valid, e_rd, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL stall_flags cyc=%0d valid/rd/busy/done=%b%b%b%b expected %b%b10",
                         cyc, valid_o, rd_mem_ld_o, busy_o, done_o, e_valid, e_rd);
            end
            if (prev_stall) begin
                checks++;
                if (data_o !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d got %h expected %h", cyc, data_o, prev_data);
                end
            end
            if (e_valid && ready_i) begin
                checks++;
                if (data_o !== rom[xfers]) begin
                    errors++;
                    $display("FAIL stall_data word=%0d got %h expected %h", xfers, data_o, rom[xfers]);
                end
                xfers++;
            end
            if (e_rd) begin
                checks++;
                if (addrs_mem_o !== AW'(reads)) begin
                    errors++;
                    $display("FAIL stall_addr got %0d expected %0d", addrs_mem_o, reads);
                end
                reads++;
            end
            prev_stall = e_valid && !ready_i;
            prev_data = data_o;
        end
        checks++;
        if (xfers != F + 1) begin
            errors++;
            $display("FAIL stall_timeout transfers %0d expected %0d", xfers, F + 1);
        end
        @(negedge clk);
        ready_i = 1'b0;
        #1;
        checks++;
        if ({done_o, busy_o, valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL stall_done done/busy/valid=%b%b%b expected 100", done_o, busy_o, valid_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_done_pulse done=%b expected 0", done_o);
        end
    endtask

    task automatic test_abort();
        bit found = 1'b0;
        @(negedge clk);
        start_i = 1'b1; ready_i = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            found = rd_mem_ld_o && (addrs_mem_o == AW'(2));
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach got no read of address 2 expected one");
        end
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, valid_o, done_o, addrs_mem_o} !== {3'b000, AW'(0)}) begin
            errors++;
            $display("FAIL abort_state busy/valid/done=%b%b%b addr=%0d expected 000 addr 0",
                     busy_o, valid_o, done_o, addrs_mem_o);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet done=%b busy=%b expected 0 0", done_o, busy_o);
            end
        end
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        checks++;
        if (rd_mem_ld_o !== 1'b1 || addrs_mem_o !== '0) begin
            errors++;
            $display("FAIL abort_restart rd=%b addr=%0d expected 1 0", rd_mem_ld_o, addrs_mem_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (valid_o !== 1'b1 || data_o !== rom[0]) begin
            errors++;
            $display("FAIL abort_restart_data valid=%b data=%h expected 1 %h", valid_o, data_o, rom[0]);
        end
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
    endtask

    // start held high: one complete run, the next begins right after done
    task automatic test_back_to_back();
        logic e_busy, e_done;
        @(negedge clk);
        start_i = 1'b1; ready_i = 1'b1;
        for (int k = 1; k <= F + 5; k++) begin
            @(negedge clk);
            #1;
            e_busy = (k <= F + 2) || (k >= F + 4);
            e_done = (k == F + 3);
            checks++;
            if (busy_o !== e_busy || done_o !== e_done) begin
                errors++;
                $display("FAIL b2b_flags cyc=%0d busy=%b done=%b expected %b %b", k, busy_o, done_o, e_busy, e_done);
            end
            if (k == F + 4) begin
                checks++;
                if (addrs_mem_o !== '0 || rd_mem_ld_o !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_restart addr=%0d rd=%b expected 0 1", addrs_mem_o, rd_mem_ld_o);
                end
            end
        end
        start_i = 1'b0;
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start_i = 1'b1; ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (valid_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL arst_setup valid=%b busy=%b expected 1 1", valid_o, busy_o);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({addrs_mem_o, rd_mem_ld_o, data_o, valid_o, busy_o, done_o} !== '0) begin
            errors++;
            $display("FAIL arst_values addr=%0d rd=%b data=%h valid=%b busy=%b done=%b expected all zero",
                     addrs_mem_o, rd_mem_ld_o, data_o, valid_o, busy_o, done_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

`ifdef ROM_CTRL_LOOP_EN
    task automatic test_loop();
        @(negedge clk);
        start_i = 1'b1; ready_i = 1'b1;
        for (int k = 1; k <= 3 * (F + 1) + 3; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            loop_i = (k - 1 < 12);
            #1;
            if (k <= 3 * (F + 1)) begin
                checks++;
                if (rd_mem_ld_o !== 1'b1 || addrs_mem_o !== AW'((k - 1) % (F + 1))) begin
                    errors++;
                    $display("FAIL loop_addr cyc=%0d rd=%b addr=%0d expected 1 %0d",
                             k, rd_mem_ld_o, addrs_mem_o, (k - 1) % (F + 1));
                end
            end
            if (k >= 2 && k <= 3 * (F + 1) + 1) begin
                checks++;
                if (valid_o !== 1'b1 || data_o !== rom[(k - 2) % (F + 1)]) begin
                    errors++;
                    $display("FAIL loop_data cyc=%0d valid=%b data=%h expected 1 %h",
                             k, valid_o, data_o, rom[(k - 2) % (F + 1)]);
                end
            end
            checks++;
            if (done_o !== (k == 3 * (F + 1) + 2)) begin
                errors++;
                $display("FAIL loop_done cyc=%0d done=%b", k, done_o);
            end
        end
        loop_i = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = {8'($urandom()), $urandom(), $urandom()};
        end
        test_reset();
        test_stream();
        test_stall();
        test_abort();
        test_back_to_back();
        test_async_reset();
`ifdef ROM_CTRL_LOOP_EN
        test_loop();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
